// File: rtl/fix_lpf_seq_if.sv
// fix_lpf_seq_if: sample handshake, output strobe and coefficient-table link
// for the fix_lpf_seq sequencer. The slave side is the sequencer itself; the
// master side is the sample source plus the fix_lpf_table coefficient ROM.
interface fix_lpf_seq_if;
  logic [1:0]         cutoff_sel;
  logic signed [15:0] din;
  logic               din_vld;
  logic               din_rdy;

  logic               sel_lpf_0p1875;
  logic               sel_lpf_0p325;
  logic               sel_lpf_0p75;

  logic signed [15:0] lpf_b1;
  logic signed [15:0] lpf_b2;
  logic signed [15:0] lpf_b3;
  logic signed [15:0] lpf_b4;
  logic signed [15:0] lpf_b5;
  logic signed [15:0] lpf_b6;
  logic signed [15:0] lpf_a1;
  logic signed [15:0] lpf_a2;
  logic signed [15:0] lpf_a3;
  logic signed [15:0] lpf_a4;
  logic signed [15:0] lpf_a5;
  logic signed [15:0] lpf_a6;

  logic signed [15:0] dout;
  logic               dout_vld;
  logic               sat;

  modport slave (
    input  cutoff_sel, din, din_vld,
    input  lpf_b1, lpf_b2, lpf_b3, lpf_b4, lpf_b5, lpf_b6,
    input  lpf_a1, lpf_a2, lpf_a3, lpf_a4, lpf_a5, lpf_a6,
    output din_rdy, sel_lpf_0p1875, sel_lpf_0p325, sel_lpf_0p75,
    output dout, dout_vld, sat
  );

  modport master (
    output cutoff_sel, din, din_vld,
    output lpf_b1, lpf_b2, lpf_b3, lpf_b4, lpf_b5, lpf_b6,
    output lpf_a1, lpf_a2, lpf_a3, lpf_a4, lpf_a5, lpf_a6,
    input  din_rdy, sel_lpf_0p1875, sel_lpf_0p325, sel_lpf_0p75,
    input  dout, dout_vld, sat
  );
endinterface

// File: rtl/fix_lpf_seq.sv
// fix_lpf_seq: time-multiplexed Direct Form I sequencer for the 5th-order Q10
// low-pass IIR. One shared 16x16 MAC, 11 products per sample, 13 cycles per
// sample in filter mode and 2 in bypass. History is flushed whenever the
// accepted cutoff differs from the active one.
// Optional feature: define FIX_LPF_SEQ_SAT_EN to clip the output to 16 bits
// and report clipping on sat; otherwise the output wraps and sat stays 0.
module fix_lpf_seq #(
  parameter int unsigned ACC_W = 40
) (
  input  logic         clk,
  input  logic         rst,
  fix_lpf_seq_if.slave bus
);

  localparam int unsigned DW     = 16;
  localparam int unsigned PW     = 32;
  localparam int unsigned KW     = 4;
  localparam int unsigned HD     = 5;
  localparam logic [KW-1:0] K_FB   = KW'(6);
  localparam logic [KW-1:0] K_LAST = KW'(10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;
  logic                    w_mac;
  logic                    w_out;

  logic [KW-1:0]           r_k;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [DW-1:0]    r_x [0:HD];
  logic signed [DW-1:0]    r_y [1:HD];
  logic [1:0]              r_sel;

  logic                    r_din_rdy;
  logic signed [DW-1:0]    r_dout;
  logic                    r_dout_vld;
  logic                    r_sat;
  logic                    r_sel_0p1875;
  logic                    r_sel_0p325;
  logic                    r_sel_0p75;

  logic signed [DW-1:0]    w_coef;
  logic signed [DW-1:0]    w_hist;
  logic signed [PW-1:0]    w_prod;
  logic signed [ACC_W-1:0] w_term;
  logic signed [ACC_W-1:0] w_rnd;
  logic signed [DW-1:0]    w_res;
  logic                    w_clip;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mac       = 1'b0;
    w_out       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.din_vld && r_din_rdy) begin
          w_accept    = 1'b1;
          w_state_nxt = (bus.cutoff_sel == 2'd0) ? S_OUT : S_MAC;
        end
      end
      S_MAC: begin
        w_mac = 1'b1;
        if (r_k == K_LAST) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        w_out       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // MAC operand select: feed-forward taps for k=0..5, feedback taps for k=6..10
  always_comb begin
    w_coef = '0;
    w_hist = '0;
    case (r_k)
      4'd0:    begin w_coef = bus.lpf_b1; w_hist = r_x[0]; end
      4'd1:    begin w_coef = bus.lpf_b2; w_hist = r_x[1]; end
      4'd2:    begin w_coef = bus.lpf_b3; w_hist = r_x[2]; end
      4'd3:    begin w_coef = bus.lpf_b4; w_hist = r_x[3]; end
      4'd4:    begin w_coef = bus.lpf_b5; w_hist = r_x[4]; end
      4'd5:    begin w_coef = bus.lpf_b6; w_hist = r_x[5]; end
      4'd6:    begin w_coef = bus.lpf_a2; w_hist = r_y[1]; end
      4'd7:    begin w_coef = bus.lpf_a3; w_hist = r_y[2]; end
      4'd8:    begin w_coef = bus.lpf_a4; w_hist = r_y[3]; end
      4'd9:    begin w_coef = bus.lpf_a5; w_hist = r_y[4]; end
      4'd10:   begin w_coef = bus.lpf_a6; w_hist = r_y[5]; end
      default: begin w_coef = '0;         w_hist = '0;     end
    endcase
  end

  assign w_prod = w_coef * w_hist;
  assign w_term = ACC_W'(w_prod);

  // Q10 round-half-up back to sample scale
  assign w_rnd = (r_acc + ACC_W'(32'sd512)) >>> 10;

`ifdef FIX_LPF_SEQ_SAT_EN
  // Clip the rounded result into the signed 16-bit range
  always_comb begin
    w_res  = DW'(w_rnd);
    w_clip = 1'b0;
    if (w_rnd > ACC_W'(32'sd32767)) begin
      w_res  = 16'sh7fff;
      w_clip = 1'b1;
    end else if (w_rnd < ACC_W'(-32'sd32768)) begin
      w_res  = 16'sh8000;
      w_clip = 1'b1;
    end
  end
`else
  assign w_res  = DW'(w_rnd);
  assign w_clip = 1'b0;
`endif

  // Datapath: accept/latch, accumulate, output and history update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k          <= '0;
      r_acc        <= '0;
      r_sel        <= 2'd0;
      r_din_rdy    <= 1'b1;
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_sat        <= 1'b0;
      r_sel_0p1875 <= 1'b0;
      r_sel_0p325  <= 1'b0;
      r_sel_0p75   <= 1'b0;
      r_x[0]       <= '0;
      for (int i = 1; i <= HD; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
      end
    end else begin
      r_dout_vld <= 1'b0;
      r_sat      <= 1'b0;

      if (w_accept) begin
        r_x[0]       <= bus.din;
        r_acc        <= '0;
        r_k          <= '0;
        r_din_rdy    <= 1'b0;
        r_sel        <= bus.cutoff_sel;
        r_sel_0p1875 <= (bus.cutoff_sel == 2'd1);
        r_sel_0p325  <= (bus.cutoff_sel == 2'd2);
        r_sel_0p75   <= (bus.cutoff_sel == 2'd3);
        if (bus.cutoff_sel != r_sel) begin
          for (int i = 1; i <= HD; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
          end
        end
      end

      if (w_mac) begin
        r_acc <= (r_k < K_FB) ? (r_acc + w_term) : (r_acc - w_term);
        r_k   <= r_k + KW'(1);
      end

      if (w_out) begin
        r_din_rdy  <= 1'b1;
        r_dout_vld <= 1'b1;
        if (r_sel == 2'd0) begin
          r_dout <= r_x[0];
          for (int i = 1; i <= HD; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
          end
        end else begin
          r_dout <= w_res;
          r_sat  <= w_clip;
          for (int i = HD; i >= 2; i--) begin
            r_x[i] <= r_x[i-1];
            r_y[i] <= r_y[i-1];
          end
          r_x[1] <= r_x[0];
          r_y[1] <= w_res;
        end
      end
    end
  end

  assign bus.din_rdy        = r_din_rdy;
  assign bus.dout           = r_dout;
  assign bus.dout_vld       = r_dout_vld;
  assign bus.sat            = r_sat;
  assign bus.sel_lpf_0p1875 = r_sel_0p1875;
  assign bus.sel_lpf_0p325  = r_sel_0p325;
  assign bus.sel_lpf_0p75   = r_sel_0p75;

endmodule

// File: tb/tb_fix_lpf_seq.sv
// tb_fix_lpf_seq: directed bench for fix_lpf_seq. A small coefficient table
// stands in for fix_lpf_table; its values are chosen so that the hand-worked
// outputs below follow from the Q10 difference equation.
`timescale 1ns/1ps
module tb_fix_lpf_seq;

  logic clk;
  logic rst;
  fix_lpf_seq_if bus();

  int n_err;
  int n_chk;

  logic signed [15:0] g_y;
  logic               g_sat;
  logic [2:0]         g_sel;
  int                 g_lat;
  int                 g_rdy0;
  logic               g_rdy_out;

  fix_lpf_seq #(.ACC_W(40)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient table model driven from the registered select lines
  always_comb begin
    bus.lpf_b1 = '0; bus.lpf_b2 = '0; bus.lpf_b3 = '0;
    bus.lpf_b4 = '0; bus.lpf_b5 = '0; bus.lpf_b6 = '0;
    bus.lpf_a1 = 16'sd1024;
    bus.lpf_a2 = '0; bus.lpf_a3 = '0; bus.lpf_a4 = '0;
    bus.lpf_a5 = '0; bus.lpf_a6 = '0;
    if (bus.sel_lpf_0p1875) begin
      bus.lpf_b1 = 16'sd30;  bus.lpf_b2 = 16'sd48;  bus.lpf_b3 = 16'sd60;
      bus.lpf_b4 = 16'sd48;  bus.lpf_b5 = 16'sd30;
      bus.lpf_a2 = -16'sd10; bus.lpf_a3 = -16'sd900;
    end else if (bus.sel_lpf_0p325) begin
      bus.lpf_b1 = 16'sd54;  bus.lpf_b2 = 16'sd100; bus.lpf_b3 = 16'sd150;
      bus.lpf_b4 = 16'sd100; bus.lpf_b5 = 16'sd54;
      bus.lpf_a2 = -16'sd300; bus.lpf_a3 = 16'sd200;
    end else if (bus.sel_lpf_0p75) begin
      bus.lpf_b1 = 16'sd321; bus.lpf_b2 = 16'sd651; bus.lpf_b3 = 16'sd249;
      bus.lpf_b4 = -16'sd191;
      bus.lpf_a2 = 16'sd2;   bus.lpf_a3 = 16'sd4;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one sample, wait for acceptance and for the matching dout_vld
  task automatic send(input logic [1:0] sel, input logic signed [15:0] x);
    int n;
    n = 0;
    @(negedge clk);
    bus.cutoff_sel = sel;
    bus.din        = x;
    bus.din_vld    = 1'b1;
    while (!bus.din_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", n, 0);
    @(posedge clk);
    #1;
    bus.din_vld    = 1'b0;
    bus.din        = 16'sh5a5a;
    bus.cutoff_sel = ~sel;
    g_sel  = {bus.sel_lpf_0p75, bus.sel_lpf_0p325, bus.sel_lpf_0p1875};
    g_rdy0 = (bus.din_rdy == 1'b0) ? 1 : 0;
    g_lat  = 0;
    g_y    = '0;
    g_sat  = 1'b0;
    g_rdy_out = 1'b0;
    while (g_lat < 40) begin
      @(posedge clk);
      #1;
      g_lat++;
      if (bus.dout_vld) break;
      if (!bus.din_rdy) g_rdy0++;
    end
    if (!bus.dout_vld) chk("dout_vld_timeout", g_lat, 12);
    g_y       = bus.dout;
    g_sat     = bus.sat;
    g_rdy_out = bus.din_rdy;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic signed [15:0] y_last;
    n_err = 0;
    n_chk = 0;
    rst            = 1'b1;
    bus.cutoff_sel = 2'd0;
    bus.din        = '0;
    bus.din_vld    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_din_rdy", int'(bus.din_rdy), 1);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_dout_vld", int'(bus.dout_vld), 0);
    chk("rst_sat", int'(bus.sat), 0);
    chk("rst_sel", int'({bus.sel_lpf_0p75, bus.sel_lpf_0p325, bus.sel_lpf_0p1875}), 0);
    rst = 1'b0;

    // Bypass
    send(2'd0, 16'sd1234);
    chk("byp_dout", int'(g_y), 1234);
    chk("byp_lat", g_lat, 1);
    chk("byp_sel", int'(g_sel), 0);
    chk("byp_rdy_low", g_rdy0, 1);

    // Impulse at 0.1875, ten samples in total
    send(2'd1, 16'sd1024);
    chk("imp0_dout", int'(g_y), 30);
    chk("imp0_lat", g_lat, 12);
    chk("imp0_rdy_low", g_rdy0, 12);
    chk("imp0_rdy_out", int'(g_rdy_out), 1);
    chk("imp0_sel", int'(g_sel), 1);
    send(2'd1, 16'sd0);
    chk("imp1_dout", int'(g_y), 48);
    @(posedge clk);
    #1;
    chk("imp1_vld_pulse", int'(bus.dout_vld), 0);
    chk("imp1_dout_hold", int'(bus.dout), 48);
    send(2'd1, 16'sd0);
    chk("imp2_dout", int'(g_y), 87);
    send(2'd1, 16'sd0);
    chk("imp3_dout", int'(g_y), 91);
    send(2'd1, 16'sd0);
    chk("imp4_dout", int'(g_y), 107);
    send(2'd1, 16'sd0);
    chk("imp5_dout", int'(g_y), 81);
    for (int i = 6; i < 10; i++) send(2'd1, 16'sd0);

    // Cutoff change flushes the ringing history
    send(2'd2, 16'sd1024);
    chk("chg_dout", int'(g_y), 54);
    chk("chg_sel", int'(g_sel), 2);

    // Reset in the middle of the MAC phase
    @(negedge clk);
    bus.cutoff_sel = 2'd1;
    bus.din        = 16'sd1024;
    bus.din_vld    = 1'b1;
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.dout_vld) seen++;
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.dout_vld) seen++;
      if (i == 2) rst = 1'b0;
    end
    chk("rstmid_no_vld", seen, 0);
    chk("rstmid_rdy", int'(bus.din_rdy), 1);
    chk("rstmid_dout", int'(bus.dout), 0);
    chk("rstmid_sel", int'({bus.sel_lpf_0p75, bus.sel_lpf_0p325, bus.sel_lpf_0p1875}), 0);
    send(2'd1, 16'sd1024);
    chk("rstmid_next", int'(g_y), 30);

    // DC at 0.75
    send(2'd3, 16'sd1000);
    chk("dc0_dout", int'(g_y), 313);
    chk("dc0_sel", int'(g_sel), 4);
    send(2'd3, 16'sd1000);
    chk("dc1_dout", int'(g_y), 949);
    y_last = g_y;
    for (int i = 2; i < 200; i++) begin
      send(2'd3, 16'sd1000);
      y_last = g_y;
    end
    chk("dc_settle", int'((y_last >= 16'sd998) && (y_last <= 16'sd1002)), 1);

    // Bypass of a negative sample also clears the DC history
    send(2'd0, -16'sd5);
    chk("byp_neg", int'(g_y), -5);
    chk("byp_neg_sat", int'(g_sat), 0);

    // Full-scale input at 0.75
    send(2'd3, 16'sd32767);
    chk("sat0_dout", int'(g_y), 10272);
    chk("sat0_flag", int'(g_sat), 0);
    send(2'd3, 16'sd32767);
    chk("sat1_dout", int'(g_y), 31083);
    chk("sat1_flag", int'(g_sat), 0);
    send(2'd3, 16'sd32767);
`ifdef FIX_LPF_SEQ_SAT_EN
    chk("sat2_dout", int'(g_y), 32767);
    chk("sat2_flag", int'(g_sat), 1);
`else
    chk("sat2_dout", int'(g_y), -26566);
    chk("sat2_flag", int'(g_sat), 0);
`endif
    @(posedge clk);
    #1;
    chk("sat2_pulse", int'(bus.sat), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fix_lpf_seq.md
# fix_lpf_seq

Time-multiplexed sequencer for the 5th-order fixed-point low-pass IIR. It accepts one audio sample per handshake and drives the cutoff-select lines of `fix_lpf_table`. It evaluates the Direct Form I difference equation on a single shared 16x16 multiply-accumulate unit, using the Q10 coefficients the table returns. It sits between the audio input stage and the noise-suppression datapath, owns all filter history, and handles cutoff changes safely at sample boundaries.

## Interface
Parameters:
- `ACC_W`, 40: signed accumulator width; must be ≥ 36.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `cutoff_sel`  in  2  filter request: 0 = bypass, 1 = 0.1875, 2 = 0.325, 3 = 0.75.
- `din`  in  16  signed input sample.
- `din_vld`  in  1  input sample valid.
- `din_rdy`  out  1  sequencer can accept a sample.
- `sel_lpf_0p1875`, `sel_lpf_0p325`, `sel_lpf_0p75`  out  1 each  registered one-hot select lines to the table; all 0 in bypass.
- `lpf_b1`..`lpf_b6`  in  16 each  signed Q10 feed-forward coefficients from the table.
- `lpf_a1`..`lpf_a6`  in  16 each  signed Q10 feedback coefficients from the table; `lpf_a1` is ignored and implied 1024.
- `dout`  out  16  signed filtered sample.
- `dout_vld`  out  1  one-cycle strobe, `dout` valid; no backpressure.
- `sat`  out  1  one-cycle strobe, the current `dout` was clipped.

## Operation
- Difference equation: y[n] = round((Σk=0..5 b(k+1)·x[n−k] − Σk=1..5 a(k+1)·y[n−k]) / 1024).
- History registers:
  - x1..x5 hold past inputs; y1..y5 hold past rounded outputs.
  - All are 16-bit signed and reset to 0.
- States:
  - IDLE: `din_rdy`=1.
    - On `din_vld`&`din_rdy`, latch `din` into x0, clear the accumulator and register `cutoff_sel` into the select lines.
    - Go to MAC, or to OUT when `cutoff_sel`=0.
  - MAC: 11 steps, k=0..10, one product per cycle.
    - k=0..5: acc += b(k+1)·x_k.
    - k=6..10: acc −= a(k−4)·y(k−5).
    - After k=10, go to OUT.
  - OUT:
    - Compute result = (acc + 512) >>> 10 (arithmetic shift).
    - Clip result to 16 bits.
    - Drive `dout`; pulse `dout_vld`.
    - Shift the histories: x5←x4 … x1←x0 and y5←y4 … y1←result.
    - Go to IDLE.
- Bypass (`cutoff_sel`=0): `dout`=x0, `sat`=0, and all history is cleared to 0.
- Cutoff change:
  - If the accepted `cutoff_sel` differs from the currently active selection, all x/y history is cleared in the same accepting edge.
  - The new sample is therefore filtered from zero state.
  - `cutoff_sel` is ignored outside the accepting edge.
- Arithmetic:
  - Each product is the full 32-bit signed product, sign-extended into `ACC_W`.
  - No intermediate saturation; the accumulator cannot overflow at 40 bits.
- Reset mid-operation: the current sample is aborted, no `dout_vld` is produced, and the FSM returns to IDLE with history zeroed.

## Timing
- Reset values:
  - `din_rdy`=1; `dout`=0; `dout_vld`=0; `sat`=0.
  - All `sel_lpf_*`=0; state IDLE.
- Filter-mode timing, with the accepting edge at E:
  - Select lines are valid from E, so the table outputs settle before MAC edges E+1..E+11.
  - `dout`/`dout_vld` are registered at E+12.
  - `din_rdy` is 0 from E through E+12 and returns to 1 after E+12.
  - Next possible accept edge is E+13, giving 13 cycles per sample.
- Bypass timing: `dout_vld` at E+1; next accept at E+2.
- `dout` holds its value until the next OUT.
- `dout_vld` and `sat` are high for exactly one cycle.
- `din` and `din_vld` asserted while `din_rdy`=0 are ignored; the sender must hold them.

## Configuration
- `FIX_LPF_SEQ_SAT_EN` defined: the result is clipped to [−32768, 32767]; `sat` pulses with `dout_vld` when clipping occurs.
- `FIX_LPF_SEQ_SAT_EN` undefined: the result is truncated to its low 16 bits (two's-complement wrap); `sat` is tied to 0.

## Test plan
- Bypass: `cutoff_sel`=0, `din`=1234 accepted at E -> `dout`=1234, `dout_vld` at E+1, all `sel_lpf_*`=0.
- Impulse at 0.1875: `cutoff_sel`=1, inputs 1024 then 0 -> first `dout`=30 at E+12, second `dout`=48; `din_rdy` low E..E+12.
- DC at 0.75: `cutoff_sel`=3, `din`=1000 repeated -> first `dout`=313; the output settles within ±2 of 1000 after about 200 samples.
- Saturation at 0.75: three samples of 32767 -> `dout` 10272, 31083, then 32767 with a `sat` pulse; without the macro the third `dout` is −26566 and `sat`=0.
- Cutoff change with flush:
  - Run 10 impulse-response samples at sel=1, then accept 1024 with sel=2 -> `dout`=54 (history cleared).
  - Select lines switch at the accepting edge.
- Reset mid-MAC: assert `rst` at E+5 -> no `dout_vld`; after release `din_rdy`=1, `dout`=0; the next 1024 at sel=1 gives 30.
